// File: rtl/stage_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode-side control, and head-of-queue outputs.
// The master side is the fetch stage; the slave side is the memory/decode environment.
interface stage_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        discard;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;

  modport master (
    output imem_req, imem_addr, pc, instr, instr_valid,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall, discard
  );

  modport slave (
    input  imem_req, imem_addr, pc, instr, instr_valid,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall, discard
  );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch: sequential PC issue to in-order imem, 2-entry return buffer; response visible 1 cycle later.
// Issue is credit-limited to 2 (in flight + buffered); decode stall freezes the head, redirect/discard squash.

module stage_fetch_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Shift-style storage: entry 0 is always the head, so it keeps its last
  // contents when the queue drains or is flushed.
  always_comb begin
    do_pop  = pop_i & (count_q != 2'd0);
    do_push = push_i & ((count_q != 2'd2) | do_pop);
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = push_dat_i;
          else                 ent1_d = push_dat_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) ent0_d = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = push_dat_i;
          end else begin
            ent0_d = push_dat_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_dat_o = ent0_q;
  assign count_o    = count_q;
endmodule

module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  stage_fetch_if.master  fe
);
  typedef enum logic {RUN, WAIT_REDIRECT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  state_e       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [1:0]   drop_cnt_q, drop_cnt_d;
  logic [1:0]   outstanding;
  logic [1:0]   outstanding_after;
  logic [1:0]   count;
  logic [2:0]   credit;
  logic [31:0]  pcq_head;
  fetch_entry_t head;
  fetch_entry_t wr_entry;
  logic         run;
  logic         flush;
  logic         consume;
  logic         accept;
  logic         wr_en;
  logic         req;
  logic         valid;

  assign run     = (state_q == RUN);
  assign flush   = fe.redirect | fe.discard;
  assign valid   = run & (count != 2'd0);
  assign consume = valid & ~fe.stall;
  assign credit  = {1'b0, outstanding} + {1'b0, count} - {2'b00, consume};
  assign req     = run & ~flush & (credit < 3'd2);
  assign accept  = req & fe.imem_ready;

  // A response is kept only outside a flush and once every pre-flush request has drained.
  assign wr_en    = fe.imem_rvalid & ~flush & (drop_cnt_q == 2'd0);
  assign wr_entry = '{pc: pcq_head, instr: fe.imem_rdata};

  // Occupancy of the in-flight PC queue is the outstanding-request count.
  assign outstanding_after = outstanding - {1'b0, fe.imem_rvalid};

  stage_fetch_fifo2 #(.W(32)) u_pc_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .push_i     (accept),
    .push_dat_i (fetch_pc_q),
    .pop_i      (fe.imem_rvalid),
    .head_dat_o (pcq_head),
    .count_o    (outstanding)
  );

  stage_fetch_fifo2 #(.W($bits(fetch_entry_t))) u_instr_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .push_i     (wr_en),
    .push_dat_i (wr_entry),
    .pop_i      (consume),
    .head_dat_o (head),
    .count_o    (count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (flush) begin
      drop_cnt_d = outstanding_after;
    end else if (fe.imem_rvalid && (drop_cnt_q != 2'd0)) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end
    if (fe.redirect) begin
      fetch_pc_d = fe.redirect_pc & 32'hFFFF_FFFC;
      state_d    = RUN;
    end else if (fe.discard) begin
      state_d    = WAIT_REDIRECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fe.imem_req    = req;
  assign fe.imem_addr   = fetch_pc_q;
  assign fe.instr_valid = valid;
  assign fe.pc          = head.pc;
  assign fe.instr       = head.instr;
endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: in-order memory model with per-request latency, scoreboard of buffered words,
// table of the reset/stall startup sequence, and directed redirect/discard/wrap/reset sequences.
module tb_stage_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct { logic [31:0] addr; int due; bit live; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { bit stall; bit req; logic [31:0] addr; bit valid; logic [31:0] pc; } vec_t;

  logic clk;
  logic rst;
  stage_fetch_if f();

  stage_fetch #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .fe(f));

  always #5 clk = ~clk;

  mem_t        memq[$];
  exp_t        exp_q[$];
  logic [31:0] acc_log[$];
  int          n_chk, n_fail, cyc, mem_lat;
  bit          stall_d, redirect_d, discard_d, ready_d, waiting;
  logic [31:0] rpc_d, exp_fetch;
  bit          s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  vec_t        tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic fail_to(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event within budget (cycle %0d)", name, cyc);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step();
    bit deliver, flush, consume, ev;
    int cr;
    mem_t m;
    ev = (exp_q.size() > 0) && !waiting;
    s_valid = f.instr_valid;
    s_pc    = f.pc;
    s_instr = f.instr;
    chk1("sb_valid", f.instr_valid, ev);
    if (ev) begin
      chk("sb_pc", f.pc, exp_q[0].pc);
      chk("sb_instr", f.instr, exp_q[0].instr);
    end
    f.stall       = stall_d;
    f.redirect    = redirect_d;
    f.discard     = discard_d;
    f.redirect_pc = rpc_d;
    f.imem_ready  = ready_d;
    deliver       = (memq.size() > 0) && (memq[0].due <= cyc);
    f.imem_rvalid = deliver;
    f.imem_rdata  = deliver ? (memq[0].addr ^ KEY) : $urandom;
    #1;
    s_req  = f.imem_req;
    s_addr = f.imem_addr;
    flush   = redirect_d | discard_d;
    consume = f.instr_valid & ~stall_d;
    cr = memq.size() + exp_q.size() - (consume ? 1 : 0);
    chk1("req", f.imem_req, !waiting && !flush && (cr < 2));
    if (f.imem_req) chk("imem_addr", f.imem_addr, exp_fetch);
    if (consume && exp_q.size() > 0) void'(exp_q.pop_front());
    if (deliver) begin
      assert (memq.size() > 0) else $error("rvalid driven with no outstanding request");
      m = memq.pop_front();
      if (!flush && m.live) exp_q.push_back('{m.addr, m.addr ^ KEY});
    end
    if (flush) begin
      exp_q.delete();
      foreach (memq[i]) memq[i].live = 1'b0;
    end
    if (f.imem_req && f.imem_ready) begin
      memq.push_back('{f.imem_addr, cyc + mem_lat, 1'b1});
      acc_log.push_back(f.imem_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect_d) begin
      exp_fetch = rpc_d & 32'hFFFF_FFFC;
      waiting = 1'b0;
    end else if (discard_d) begin
      waiting = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_acc(input string name, input logic [31:0] exp, input int budget);
    for (int i = 0; i < budget && acc_log.size() == 0; i++) step();
    if (acc_log.size() == 0) fail_to(name);
    else chk(name, acc_log[0], exp);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, input int budget);
    for (int i = 0; i < budget && !f.instr_valid; i++) step();
    if (!f.instr_valid) fail_to(name);
    else begin
      chk(name, f.pc, exp_pc);
      chk({name, "_instr"}, f.instr, exp_pc ^ KEY);
    end
  endtask

  task automatic redirect_to(input logic [31:0] a);
    acc_log.delete();
    rpc_d = a;
    redirect_d = 1'b1;
    step();
    redirect_d = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // cycle-by-cycle startup from reset release, then a 5-cycle stall
    tbl[0]  = '{0, 1, 32'h100, 0, 32'h000};
    tbl[1]  = '{0, 1, 32'h104, 0, 32'h000};
    tbl[2]  = '{0, 1, 32'h108, 1, 32'h100};
    tbl[3]  = '{0, 1, 32'h10C, 1, 32'h104};
    tbl[4]  = '{0, 1, 32'h110, 1, 32'h108};
    tbl[5]  = '{1, 0, 32'h114, 1, 32'h10C};
    tbl[6]  = '{1, 0, 32'h114, 1, 32'h10C};
    tbl[7]  = '{1, 0, 32'h114, 1, 32'h10C};
    tbl[8]  = '{1, 0, 32'h114, 1, 32'h10C};
    tbl[9]  = '{1, 0, 32'h114, 1, 32'h10C};
    tbl[10] = '{0, 1, 32'h114, 1, 32'h10C};
    tbl[11] = '{0, 1, 32'h118, 1, 32'h110};
    tbl[12] = '{0, 1, 32'h11C, 1, 32'h114};

    clk = 1'b0; rst = 1'b1;
    n_chk = 0; n_fail = 0; cyc = 0; mem_lat = 1;
    stall_d = 0; redirect_d = 0; discard_d = 0; ready_d = 1; waiting = 0;
    rpc_d = '0; exp_fetch = RPC;
    f.stall = 0; f.redirect = 0; f.discard = 0; f.redirect_pc = '0;
    f.imem_ready = 1; f.imem_rvalid = 0; f.imem_rdata = '0;
    repeat (3) @(negedge clk);
    chk1("rst_valid", f.instr_valid, 1'b0);
    chk("rst_pc", f.pc, 32'h0);
    chk("rst_instr", f.instr, 32'h0);
    chk("rst_addr", f.imem_addr, RPC);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      stall_d = tbl[i].stall;
      step();
      chk1("tbl_req", s_req, tbl[i].req);
      chk("tbl_addr", s_addr, tbl[i].addr);
      chk1("tbl_valid", s_valid, tbl[i].valid);
      chk("tbl_pc", s_pc, tbl[i].pc);
      chk("tbl_instr", s_instr, tbl[i].valid ? (tbl[i].pc ^ KEY) : 32'h0);
    end

    // redirect with two requests in flight
    mem_lat = 3;
    for (int i = 0; i < 20 && memq.size() < 2; i++) step();
    if (memq.size() < 2) fail_to("two_outstanding");
    redirect_to(32'h2000);
    chk1("redir_empty", f.instr_valid, 1'b0);
    wait_acc("redir_addr", 32'h2000, 20);
    wait_valid("redir_pc", 32'h2000, 20);
    mem_lat = 1;

    // discard without redirect holds fetch off until a redirect arrives
    repeat (3) step();
    discard_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("disc_req", s_req, 1'b0);
      chk1("disc_valid", f.instr_valid, 1'b0);
    end
    discard_d = 1'b0;
    repeat (2) begin
      step();
      chk1("wait_req", s_req, 1'b0);
    end
    redirect_to(32'h40);
    wait_acc("disc_redir_addr", 32'h40, 10);
    wait_valid("disc_redir_pc", 32'h40, 10);

    // redirect in the same cycle a response arrives, unaligned target
    for (int i = 0; i < 10 && !(memq.size() > 0 && memq[0].due <= cyc + 0 && exp_q.size() > 0); i++) step();
    redirect_to(32'h1003);
    chk1("redir_rv_empty", f.instr_valid, 1'b0);
    wait_acc("redir_rv_addr", 32'h1000, 10);
    wait_valid("redir_rv_pc", 32'h1000, 10);

    // fetch address wraps at the top of the address space
    redirect_to(32'hFFFF_FFF8);
    repeat (6) step();
    if (acc_log.size() < 3) fail_to("wrap_seq");
    else begin
      chk("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
      chk("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", acc_log[2], 32'h0000_0000);
    end

    // random stall / ready / latency / squash traffic
    for (int i = 0; i < 400; i++) begin
      stall_d   = ($urandom_range(3) == 0);
      ready_d   = ($urandom_range(3) != 0);
      mem_lat   = 1 + $urandom_range(2);
      redirect_d = waiting ? ($urandom_range(2) == 0) : ($urandom_range(39) == 0);
      discard_d  = ($urandom_range(59) == 0);
      rpc_d      = $urandom;
      step();
    end
    redirect_d = 0; discard_d = 0; ready_d = 1; mem_lat = 1;
    if (waiting) redirect_to(32'h300);
    repeat (4) step();

    // asynchronous reset with a full buffer
    stall_d = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() < 2; i++) step();
    if (exp_q.size() < 2) fail_to("fill_before_reset");
    rst = 1'b1;
    #1;
    chk1("arst_valid", f.instr_valid, 1'b0);
    chk("arst_pc", f.pc, 32'h0);
    chk("arst_instr", f.instr, 32'h0);
    memq.delete(); exp_q.delete(); acc_log.delete();
    exp_fetch = RPC; waiting = 0; stall_d = 0;
    f.imem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    cyc += 2;
    rst = 1'b0;
    wait_acc("post_rst_addr", RPC, 5);
    wait_valid("post_rst_pc", RPC, 10);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_fetch.md
# stage_fetch

Instruction-fetch stage: sits directly upstream of the decode stage and supplies its `pc_in`/`instr`/`instr_valid`. It generates sequential fetch addresses, issues them to an in-order instruction-memory port, and buffers up to two returned words with their PCs. It honours the decode stage's `stall` back-pressure and `discard` squash, and restarts from a target PC on a redirect from execute.

## Interface
- `RESET_PC`, default 32'h00000000: first fetch address after reset.
- `clk  in  1`: clock; all state changes on its rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `imem_req  out  1`: fetch request valid.
- `imem_addr  out  32`: fetch address, always word-aligned (bits [1:0] = 0).
- `imem_ready  in  1`: request accepted this cycle when `imem_req & imem_ready`.
- `imem_rvalid  in  1`: response valid; responses return in order, ≥1 cycle after acceptance.
- `imem_rdata  in  32`: instruction word.
- `redirect  in  1`: restart fetch at `redirect_pc` (jump resolved downstream).
- `redirect_pc  in  32`: new fetch PC; bits [1:0] are ignored and forced to 0.
- `stall  in  1`: decode's stall output; head is consumed when `instr_valid & ~stall`.
- `discard  in  1`: decode's discard output; squashes everything fetched so far.
- `pc  out  32`: PC of head entry.
- `instr  out  32`: instruction word of head entry.
- `instr_valid  out  1`: head entry valid.

## Operation
- State registers: `state` ∈ {RUN, WAIT_REDIRECT}; `fetch_pc` (32); `outstanding` (0..2); `drop_cnt` (0..2); 2-entry FIFO of {pc, instr}, `count` (0..2); in-flight PC queue, 2 entries.
- Reset: state=RUN, fetch_pc=RESET_PC, outstanding=drop_cnt=count=0, all FIFO/queue entries 0. Hence pc=0, instr=0, instr_valid=0.
- `consume = instr_valid & ~stall`.
- `imem_req = (state==RUN) & ~redirect & ~discard & (outstanding + count - consume < 2)`.
- `imem_addr = fetch_pc`.
- On acceptance:
  - push fetch_pc into the PC queue;
  - `fetch_pc += 4`, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000);
  - outstanding += 1.
- On `imem_rvalid`:
  - pop the PC queue; outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and the word is not written.
  - Otherwise: write {popped pc, imem_rdata} at FIFO tail.
- Accept and rvalid in the same cycle: net outstanding unchanged.
- `instr_valid = (count>0) & (state==RUN)`; pc/instr come from the head entry. When empty, they hold the last head contents.
- Flush event (`redirect | discard`):
  - FIFO cleared (count=0).
  - drop_cnt = outstanding after this cycle's arrival. A response arriving in the flush cycle is itself dropped.
  - No request is issued in the flush cycle.
- Redirect: fetch_pc = {redirect_pc[31:2],2'b00}; state=RUN.
- Discard without redirect: state=WAIT_REDIRECT. No requests are issued and instr_valid=0 until redirect. Responses are still dropped via drop_cnt.
- Redirect and discard in the same cycle: redirect wins; state=RUN.
- `imem_rvalid` while outstanding==0 is illegal; the bench asserts on it.

## Timing
- Request-to-visible latency: response in cycle N → instr_valid in cycle N+1 (no bypass).
- With a 1-cycle memory and no stall, sustained throughput is one instruction per cycle. The first instr_valid appears cycle 2 after reset release.
- Redirect in cycle N → imem_req with the new address in cycle N+1 at the earliest.
- Stall holds pc/instr/instr_valid stable. Issue continues only while credit (outstanding+count) < 2.
- Reset asserted mid-operation clears state immediately (async). Responses to pre-reset requests must not be presented after reset; the bench guarantees this.

## Test plan
- Reset release with RESET_PC=0x100 and 1-cycle, always-ready memory returning addr^0xA5A50000 → requests 0x100, 0x104, 0x108…. instr_valid is high from cycle 2 with pc=0x100, then one new pc per cycle.
- Hold stall=1 for 5 cycles in steady state → pc/instr frozen. At most 2 accepted-but-unconsumed words exist; imem_req low once credit is full. Release → sequence resumes with no gap or duplicate.
- Redirect to 0x2000 with 2 requests outstanding → both responses dropped, FIFO empty next cycle. Next request address is 0x2000; first presented pc is 0x2000.
- Discard with no redirect for 4 cycles → imem_req=0 and instr_valid=0 throughout. Redirect to 0x40 → fetch resumes at 0x40.
- Redirect and imem_rvalid in the same cycle, plus redirect_pc=0x1003 → that response is dropped; fetch restarts at 0x1000. fetch_pc at 0xFFFFFFFC wraps to 0x0.
- Assert rst mid-stream with a full FIFO → outputs 0 and instr_valid=0 immediately. After release, fetch restarts at RESET_PC.
